// File: rtl/cpu_pkg.sv
// Shared CPU definitions: architectural zero register index and register-file trace format.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cpu_pkg;

  // Architectural hard-wired zero register.
  localparam int REG_ZERO = 0;

  // One line per register write that actually lands: PC, destination, value.
  localparam string TRACE_FMT = "@%h: $%d <= %h";

endpackage

// File: rtl/grf_wr_arbiter.sv
// Write-port arbiter for one register address: does any enabled write port target addr, and which one wins.
// Latency: combinational.
// Backpressure: none; the highest-indexed matching port always wins.
// Ports: we/waddr = all write ports, addr = address under test, hit = some port targets addr,
//        idx = index of the winning (highest) matching port, 0 when no hit.
module grf_wr_arbiter #(
  parameter int NUM_WR = 2,
  parameter int ADDR_W = 5,
  parameter int IDX_W  = 1
) (
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [ADDR_W-1:0]        addr,
  output logic                     hit,
  output logic [IDX_W-1:0]         idx
);

  // Ascending scan: a later match overwrites an earlier one, so the highest index wins.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (we[j] && (waddr[j*ADDR_W +: ADDR_W] == addr)) begin
        hit = 1'b1;
        idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/grf_multiport.sv
// General-purpose register file: NUM_RD combinational read ports, NUM_WR write ports, optional
// write-to-read bypass and a per-register pending-write (busy) scoreboard for hazard stalls.
// Latency: reads 0 cycles; writes and busy updates land on the next rising clk edge.
// Backpressure: none; every write is accepted, stalls are signalled to decode through rbusy.
// Ports: clk/reset (async active-high), raddr/rdata/rbusy (read side, port k at slice k),
//        we/waddr/wdata/wpc (writeback side; wpc only feeds the trace), issue_en/issue_addr (busy set).
module grf_multiport
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_WR*32-1:0]     wpc,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int IDX_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
  // Write-data select table is padded to a power of two so any idx value is a legal index.
  localparam int NSEL  = 2**IDX_W;

  if (NUM_RD < 1 || NUM_WR < 1) begin : g_param_chk
    $fatal(1, "grf_multiport: NUM_RD and NUM_WR must both be at least 1");
  end

  logic [NUM_WR-1:0] we_eff;
  logic [DATA_W-1:0] wdata_a [NSEL];
  logic [DATA_W-1:0] regs_q  [DEPTH];
  logic [DATA_W-1:0] regs_d  [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [DEPTH-1:0]  reg_hit;
  logic [IDX_W-1:0]  reg_idx [DEPTH];
  logic [NUM_RD-1:0] rd_hit;
  logic [IDX_W-1:0]  rd_idx  [NUM_RD];

  // Writes to the zero register are squashed here, so they neither land, bypass, clear busy nor trace.
  always_comb begin
    we_eff = '0;
    for (int j = 0; j < NSEL; j++) begin
      wdata_a[j] = '0;
    end
    for (int j = 0; j < NUM_WR; j++) begin
      wdata_a[j] = wdata[j*DATA_W +: DATA_W];
      we_eff[j]  = we[j] && !((ZERO_REG != 0) && (waddr[j*ADDR_W +: ADDR_W] == ADDR_W'(REG_ZERO)));
    end
  end

  // One arbiter per register resolves the write datapath and the busy clear together.
  for (genvar r = 0; r < DEPTH; r++) begin : g_reg_arb
    grf_wr_arbiter #(
      .NUM_WR (NUM_WR),
      .ADDR_W (ADDR_W),
      .IDX_W  (IDX_W)
    ) u_wr_arb (
      .we    (we_eff),
      .waddr (waddr),
      .addr  (ADDR_W'(r)),
      .hit   (reg_hit[r]),
      .idx   (reg_idx[r])
    );
  end

  // One arbiter per read port picks the bypass source.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_arb
    grf_wr_arbiter #(
      .NUM_WR (NUM_WR),
      .ADDR_W (ADDR_W),
      .IDX_W  (IDX_W)
    ) u_rd_arb (
      .we    (we_eff),
      .waddr (waddr),
      .addr  (raddr[k*ADDR_W +: ADDR_W]),
      .hit   (rd_hit[k]),
      .idx   (rd_idx[k])
    );
  end

  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < DEPTH; r++) begin
      regs_d[r] = reg_hit[r] ? wdata_a[reg_idx[r]] : regs_q[r];
      if (reg_hit[r]) begin
        busy_d[r] = 1'b0;
      end
      // Set after clear: a newly issued producer outranks the write retiring this cycle.
      if (issue_en && (issue_addr == ADDR_W'(r))) begin
        busy_d[r] = 1'b1;
      end
    end
    if (ZERO_REG != 0) begin
      regs_d[REG_ZERO] = '0;
      busy_d[REG_ZERO] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q <= busy_d;
    end
  end

  // Reads are forced to zero while reset is high so a bypassed write cannot leak out during reset.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    if (!reset) begin
      for (int k = 0; k < NUM_RD; k++) begin
        if ((BYPASS != 0) && rd_hit[k]) begin
          rdata[k*DATA_W +: DATA_W] = wdata_a[rd_idx[k]];
          rbusy[k]                  = 1'b0;
        end else begin
          rdata[k*DATA_W +: DATA_W] = regs_q[raddr[k*ADDR_W +: ADDR_W]];
          rbusy[k]                  = busy_q[raddr[k*ADDR_W +: ADDR_W]];
        end
        if ((ZERO_REG != 0) && (raddr[k*ADDR_W +: ADDR_W] == ADDR_W'(REG_ZERO))) begin
          rdata[k*DATA_W +: DATA_W] = '0;
          rbusy[k]                  = 1'b0;
        end
      end
    end
  end

  // Trace of writes that land; a port is the winner iff its own target register picked its index.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (we_eff[j] && (reg_idx[waddr[j*ADDR_W +: ADDR_W]] == IDX_W'(j))) begin
          $display(TRACE_FMT, wpc[j*32 +: 32], waddr[j*ADDR_W +: ADDR_W], wdata[j*DATA_W +: DATA_W]);
        end
      end
    end
  end

endmodule

// File: tb/tb_grf_multiport.sv
module tb_grf_multiport;

  typedef struct {
    string       name;
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic        ie;
    logic [4:0]  ia;
    logic [31:0] e_rd0, e_rd1;   // bypassing instance, ports 0/1
    logic [1:0]  e_busy;         // bypassing instance rbusy
    logic [31:0] e_nb0;          // non-bypassing instance, port 0
    logic        e_nbb;          // non-bypassing instance rbusy[0]
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  raddr;
  logic [63:0] rdata, rdata_nb;
  logic [1:0]  rbusy, rbusy_nb;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [63:0] wpc;
  logic        issue_en;
  logic [4:0]  issue_addr;

  logic [19:0]  w_raddr;
  logic [255:0] w_rdata;
  logic [3:0]   w_rbusy;
  logic [0:0]   w_we;
  logic [4:0]   w_waddr;
  logic [63:0]  w_wdata;
  logic [31:0]  w_wpc;
  logic         w_issue_en;
  logic [4:0]   w_issue_addr;

  int n_vec = 0;
  int n_err = 0;

  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  grf_multiport u_dut (
    .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we(we), .waddr(waddr), .wdata(wdata), .wpc(wpc),
    .issue_en(issue_en), .issue_addr(issue_addr)
  );

  grf_multiport #(.BYPASS(0)) u_dut_nb (
    .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb),
    .we(we), .waddr(waddr), .wdata(wdata), .wpc(wpc),
    .issue_en(issue_en), .issue_addr(issue_addr)
  );

  grf_multiport #(.NUM_RD(4), .NUM_WR(1), .DATA_W(64)) u_dut_wide (
    .clk(clk), .reset(reset), .raddr(w_raddr), .rdata(w_rdata), .rbusy(w_rbusy),
    .we(w_we), .waddr(w_waddr), .wdata(w_wdata), .wpc(w_wpc),
    .issue_en(w_issue_en), .issue_addr(w_issue_addr)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [1:0] we_i,
                              input logic [4:0] wa0, input logic [31:0] wd0,
                              input logic [4:0] wa1, input logic [31:0] wd1,
                              input logic [4:0] ra0, input logic [4:0] ra1,
                              input logic ie, input logic [4:0] ia,
                              input logic [31:0] e_rd0, input logic [31:0] e_rd1,
                              input logic [1:0] e_busy, input logic [31:0] e_nb0,
                              input logic e_nbb);
    vec_t v;
    v.name = nm; v.we = we_i; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ra0 = ra0; v.ra1 = ra1; v.ie = ie; v.ia = ia;
    v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_busy = e_busy; v.e_nb0 = e_nb0; v.e_nbb = e_nbb;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    we         = v.we;
    waddr      = {v.wa1, v.wa0};
    wdata      = {v.wd1, v.wd0};
    raddr      = {v.ra1, v.ra0};
    issue_en   = v.ie;
    issue_addr = v.ia;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vec_t e;
    logic [63:0] wide_val [4];

    //            name            we     wa0   wd0       wa1   wd1       ra0   ra1   ie    ia     rd0       rd1       busy   nb0       nbb
    tbl.push_back(mk("rst_discard", 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,    5'd5, 5'd9, 1'b0, 5'd0, 32'h0,    32'h0,    2'b00, 32'h0,    1'b0));
    tbl.push_back(mk("wr_r5",       2'b01, 5'd5, 32'h1234, 5'd0, 32'h0,    5'd5, 5'd0, 1'b0, 5'd0, 32'h1234, 32'h0,    2'b00, 32'h0,    1'b0));
    tbl.push_back(mk("rd_r5",       2'b00, 5'd0, 32'h0,    5'd0, 32'h0,    5'd5, 5'd0, 1'b0, 5'd0, 32'h1234, 32'h0,    2'b00, 32'h1234, 1'b0));
    tbl.push_back(mk("prio_wr",     2'b11, 5'd7, 32'hAAAA, 5'd7, 32'hBBBB, 5'd7, 5'd5, 1'b0, 5'd0, 32'hBBBB, 32'h1234, 2'b00, 32'h0,    1'b0));
    tbl.push_back(mk("prio_rd",     2'b00, 5'd0, 32'h0,    5'd0, 32'h0,    5'd7, 5'd5, 1'b0, 5'd0, 32'hBBBB, 32'h1234, 2'b00, 32'hBBBB, 1'b0));
    tbl.push_back(mk("byp_r3",      2'b10, 5'd0, 32'h0,    5'd3, 32'hCAFE, 5'd3, 5'd7, 1'b0, 5'd0, 32'hCAFE, 32'hBBBB, 2'b00, 32'h0,    1'b0));
    tbl.push_back(mk("byp_r3_next", 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,    5'd3, 5'd7, 1'b0, 5'd0, 32'hCAFE, 32'hBBBB, 2'b00, 32'hCAFE, 1'b0));
    tbl.push_back(mk("zero_wr",     2'b01, 5'd0, 32'hFFFF, 5'd0, 32'h0,    5'd0, 5'd0, 1'b1, 5'd0, 32'h0,    32'h0,    2'b00, 32'h0,    1'b0));
    tbl.push_back(mk("zero_chk",    2'b00, 5'd0, 32'h0,    5'd0, 32'h0,    5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    32'h0,    2'b00, 32'h0,    1'b0));
    tbl.push_back(mk("issue_r9",    2'b00, 5'd0, 32'h0,    5'd0, 32'h0,    5'd9, 5'd9, 1'b1, 5'd9, 32'h0,    32'h0,    2'b00, 32'h0,    1'b0));
    tbl.push_back(mk("r9_busy",     2'b00, 5'd0, 32'h0,    5'd0, 32'h0,    5'd9, 5'd5, 1'b0, 5'd0, 32'h0,    32'h1234, 2'b01, 32'h0,    1'b1));
    tbl.push_back(mk("r9_reissue",  2'b01, 5'd9, 32'h9999, 5'd0, 32'h0,    5'd9, 5'd9, 1'b1, 5'd9, 32'h9999, 32'h9999, 2'b00, 32'h0,    1'b1));
    tbl.push_back(mk("r9_still",    2'b00, 5'd0, 32'h0,    5'd0, 32'h0,    5'd9, 5'd9, 1'b0, 5'd0, 32'h9999, 32'h9999, 2'b11, 32'h9999, 1'b1));
    tbl.push_back(mk("r9_clr",      2'b10, 5'd0, 32'h0,    5'd9, 32'hABCD, 5'd9, 5'd7, 1'b0, 5'd0, 32'hABCD, 32'hBBBB, 2'b00, 32'h9999, 1'b1));
    tbl.push_back(mk("r9_idle",     2'b00, 5'd0, 32'h0,    5'd0, 32'h0,    5'd9, 5'd3, 1'b0, 5'd0, 32'hABCD, 32'hCAFE, 2'b00, 32'hABCD, 1'b0));
    tbl.push_back(mk("issue_r12",   2'b00, 5'd0, 32'h0,    5'd0, 32'h0,    5'd12,5'd9, 1'b1, 5'd12,32'h0,    32'hABCD, 2'b00, 32'h0,    1'b0));
    tbl.push_back(mk("r12_busy",    2'b00, 5'd0, 32'h0,    5'd0, 32'h0,    5'd12,5'd12,1'b0, 5'd0, 32'h0,    32'h0,    2'b11, 32'h0,    1'b1));
    tbl.push_back(mk("clr_idle_r20",2'b01, 5'd20,32'h5,    5'd0, 32'h0,    5'd20,5'd12,1'b0, 5'd0, 32'h5,    32'h0,    2'b10, 32'h0,    1'b0));
    tbl.push_back(mk("r12_wr",      2'b01, 5'd12,32'h1212, 5'd0, 32'h0,    5'd12,5'd20,1'b0, 5'd0, 32'h1212, 32'h5,    2'b00, 32'h0,    1'b1));
    tbl.push_back(mk("r12_idle",    2'b00, 5'd0, 32'h0,    5'd0, 32'h0,    5'd12,5'd12,1'b0, 5'd0, 32'h1212, 32'h1212, 2'b00, 32'h1212, 1'b0));
    tbl.push_back(mk("dual_wr",     2'b11, 5'd1, 32'h1111, 5'd2, 32'h2222, 5'd1, 5'd2, 1'b0, 5'd0, 32'h1111, 32'h2222, 2'b00, 32'h0,    1'b0));
    tbl.push_back(mk("dual_rd",     2'b00, 5'd0, 32'h0,    5'd0, 32'h0,    5'd1, 5'd2, 1'b0, 5'd0, 32'h1111, 32'h2222, 2'b00, 32'h1111, 1'b0));

    wpc          = {32'h0000_2004, 32'h0000_2000};
    w_wpc        = 32'h0000_3000;
    w_we         = 1'b0;
    w_waddr      = '0;
    w_wdata      = '0;
    w_raddr      = '0;
    w_issue_en   = 1'b0;
    w_issue_addr = '0;

    // Reset state, with a write and an issue held on the inputs that must not leak through.
    reset = 1'b1;
    v = mk("in_reset", 2'b01, 5'd5, 32'h77, 5'd0, 32'h0, 5'd5, 5'd9, 1'b1, 5'd9,
           32'h0, 32'h0, 2'b00, 32'h0, 1'b0);
    apply(v);
    #2;
    chk("reset_rdata",    rdata,           64'h0);
    chk("reset_rbusy",    64'(rbusy),      64'h0);
    chk("reset_rdata_nb", rdata_nb,        64'h0);
    chk("reset_wide",     w_rdata[63:0],   64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Table: drive, queue the expectation, compare at the falling edge, then let the edge commit.
    foreach (tbl[i]) begin
      apply(tbl[i]);
      sb.push_back(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      chk({e.name, ".rd0"},  64'(rdata[31:0]),    64'(e.e_rd0));
      chk({e.name, ".rd1"},  64'(rdata[63:32]),   64'(e.e_rd1));
      chk({e.name, ".busy"}, 64'(rbusy),          64'(e.e_busy));
      chk({e.name, ".nb0"},  64'(rdata_nb[31:0]), 64'(e.e_nb0));
      chk({e.name, ".nbb"},  64'(rbusy_nb[0]),    64'(e.e_nbb));
      @(posedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end

    // Reset pulsed between edges: storage and busy must clear without a clock edge.
    v = mk("pre_rst", 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd12, 1'b1, 5'd12,
           32'h0, 32'h0, 2'b00, 32'h0, 1'b0);
    apply(v);
    @(posedge clk);
    #1;
    issue_en = 1'b0;
    #1;
    chk("midrst_pre_r5",    64'(rdata[31:0]), 64'h1234);
    chk("midrst_pre_busy",  64'(rbusy),       64'h2);
    reset = 1'b1;
    #1;
    chk("midrst_r5",        64'(rdata[31:0]),    64'h0);
    chk("midrst_busy",      64'(rbusy),          64'h0);
    chk("midrst_r5_nb",     64'(rdata_nb[31:0]), 64'h0);
    #1;
    reset = 1'b0;
    #1;
    chk("postrst_r5",       64'(rdata[31:0]),    64'h0);
    chk("postrst_busy",     64'(rbusy),          64'h0);
    @(posedge clk);
    #1;
    raddr = {5'd12, 5'd7};
    #1;
    chk("postrst_r7",       64'(rdata[31:0]), 64'h0);
    chk("postrst_busy_r12", 64'(rbusy),       64'h0);

    // Wide instance: four 64-bit writes, then all four ports read distinct registers.
    wide_val[0] = 64'hDEAD_BEEF_0000_0001;
    wide_val[1] = 64'h1234_5678_9ABC_DEF0;
    wide_val[2] = 64'hFFFF_0000_FFFF_0000;
    wide_val[3] = 64'h8000_0001_7FFF_FFFE;
    w_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_waddr = 5'(i + 1);
      w_wdata = wide_val[i];
      @(posedge clk);
      #1;
    end
    w_we    = 1'b0;
    w_raddr = {5'd4, 5'd3, 5'd2, 5'd1};
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wide_port%0d", k), w_rdata[k*64 +: 64], wide_val[k]);
    end
    w_raddr = {5'd1, 5'd2, 5'd3, 5'd4};
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wide_rev_port%0d", k), w_rdata[k*64 +: 64], wide_val[3-k]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
